fp_result_accumulator: RTL and testbench

Downstream consumer of the `inner_function` pipeline. It sums a run of N single-precision results, each arriving with the `done` strobe as its valid, into one float.

- Uses a single pipelined `fp_addsub_custom` whose latency ring holds up to FP_ADD_LATENCY interleaved partial sums.
- After the last sample, a reduction phase folds the partial sums into one value.
- Presents the total to the Nios custom-instruction wrapper with a one-cycle `done`.

---
 rtl/fp_acc_pkg.sv | 23 ++
 rtl/fp_acc_tag_ring.sv | 35 +++
 rtl/fp_addsub_custom.sv | 93 +++++++++
 rtl/fp_result_accumulator.sv | 157 +++++++++++++++
 tb/tb_fp_result_accumulator.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the float result accumulator.
// Default latencies here are also used by inner_function.
package fp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REDUCE = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam logic [31:0] FP_ZERO         = 32'h0000_0000;
  localparam logic [31:0] FP_EXP_ALL_ONES = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;

  localparam int FP_ADD_LATENCY_DEF = 11;
  localparam int CNT_W_DEF          = 16;

  function automatic logic is_nan_inf(input logic [31:0] x);
    return (x & FP_EXP_ALL_ONES) == FP_EXP_ALL_ONES;
  endfunction

endpackage

// File: rtl/fp_acc_tag_ring.sv
// Tag shift register in lockstep with the adder pipeline.
// A set bit means that adder stage carries a live partial sum.
import fp_acc_pkg::*;

module fp_acc_tag_ring #(
  parameter int L  = FP_ADD_LATENCY_DEF,
  parameter int PW = $clog2(L + 1)
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          clk_en,
  input  logic          clr,
  input  logic          tag_in,
  output logic          etag,
  output logic [PW-1:0] count
);

  logic [L-1:0] tags;

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr)
      tags <= '0;
    else if (clk_en)
      tags <= clr ? '0 : {tags[L-2:0], tag_in};
  end

  assign etag = tags[L-1];

  always_comb begin
    count = '0;
    for (int i = 0; i < L; i++)
      count = count + PW'(tags[i]);
  end

endmodule

// File: rtl/fp_addsub_custom.sv
// Pipelined IEEE-754 single adder/subtractor, round-to-nearest-even.
// Denormals flush to zero; add_sub=1 adds, 0 subtracts.
import fp_acc_pkg::*;

module fp_addsub_custom #(
  parameter int LATENCY = FP_ADD_LATENCY_DEF
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        add_sub,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  logic [31:0] bx, x, y, res;
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, ys, msk;
  logic [27:0] s;
  logic [24:0] mr;
  logic signed [9:0] e, ef;
  logic        up, sx;
  logic [31:0] pipe [LATENCY];

  always_comb begin
    bx = {datab[31] ^ ~add_sub, datab[30:0]};
    if (bx[30:0] > dataa[30:0]) begin
      x = bx;
      y = dataa;
    end else begin
      x = dataa;
      y = bx;
    end
    ex  = x[30:23];
    ey  = y[30:23];
    sx  = x[31];
    mx  = (ex == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    my  = (ey == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    d   = ex - ey;
    msk = (27'd1 << d) - 27'd1;
    if (d >= 8'd27)
      ys = {26'd0, |my};
    else
      ys = (my >> d) | {26'd0, |(my & msk)};
    if (x[31] == y[31])
      s = {1'b0, mx} + {1'b0, ys};
    else
      s = {1'b0, mx} - {1'b0, ys};
    e = $signed({2'b00, ex});
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26] && s != 28'd0) begin
        s = s << 1;
        e = e - 10'sd1;
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    mr = {1'b0, s[26:3]} + {24'd0, up};
    ef = mr[24] ? e + 10'sd1 : e;
    // hidden bit and rounding carry ripple into the exponent field
    res = {sx, {8'(e - 10'sd1), 23'd0} + {6'd0, mr}};
    if (s == 28'd0)
      res = FP_ZERO;
    else if (ef >= 10'sd255)
      res = {sx, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      res = {sx, 31'd0};
    if (ex == 8'hFF || ey == 8'hFF) begin
      if ((ex == 8'hFF && x[22:0] != 23'd0) ||
          (ey == 8'hFF && y[22:0] != 23'd0) ||
          (ey == 8'hFF && x[31] != y[31]))
        res = FP_QNAN;
      else
        res = {sx, 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= FP_ZERO;
    end else if (clk_en) begin
      pipe[0] <= res;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign result = pipe[LATENCY-1];

endmodule

// File: rtl/fp_result_accumulator.sv
// Sums N float samples through one pipelined adder, then reduces.
// Build option: FP_ACC_NAN_DETECT_EN enables the sticky nan_flag.
import fp_acc_pkg::*;

module fp_result_accumulator #(
  parameter int FP_ADD_LATENCY = FP_ADD_LATENCY_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sum,
  output logic             drop_err,
  output logic             nan_flag
);

  localparam int L  = FP_ADD_LATENCY;
  localparam int PW = $clog2(L + 1);

  state_t state_q, state_d;
  logic [CNT_W-1:0] n_q, cnt_q;
  logic [31:0] hold_q, sum_q, dataa, datab, emerge;
  logic hv_q, drop_q;
  logic accept, etag, tag_in, ring_clr;
  logic load_hold, clr_hv, fin_go, start_go;
  logic [PW-1:0] count;
  logic [PW:0]   p;

  assign in_ready = (state_q == ACCUM) && (cnt_q < n_q);
  assign accept   = in_valid & in_ready;
  assign busy     = state_q != IDLE;
  assign done     = state_q == FIN;
  assign sum      = sum_q;
  assign drop_err = drop_q;
  assign start_go = (state_q == IDLE) && start;
  assign p        = {1'b0, count} + {{PW{1'b0}}, hv_q};
  assign fin_go   = (state_q == REDUCE) && (state_d == FIN);

  always_comb begin
    state_d   = state_q;
    dataa     = FP_ZERO;
    datab     = FP_ZERO;
    tag_in    = 1'b0;
    ring_clr  = 1'b0;
    load_hold = 1'b0;
    clr_hv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ring_clr = 1'b1;
          state_d  = (n == '0) ? FIN : ACCUM;
        end
      end
      ACCUM: begin
        dataa  = etag ? emerge : FP_ZERO;
        datab  = accept ? in_data : FP_ZERO;
        tag_in = etag | accept;
        if (cnt_q == n_q) state_d = REDUCE;
      end
      REDUCE: begin
        // pair each emerging partial with the held one
        if (etag && !hv_q) begin
          load_hold = 1'b1;
        end else if (etag && hv_q) begin
          dataa  = hold_q;
          datab  = emerge;
          tag_in = 1'b1;
          clr_hv = 1'b1;
        end
        if (p == (PW+1)'(1) && hv_q) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      hold_q  <= FP_ZERO;
      hv_q    <= 1'b0;
      sum_q   <= FP_ZERO;
      drop_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (start_go) begin
        n_q    <= n;
        cnt_q  <= '0;
        drop_q <= 1'b0;
        hv_q   <= 1'b0;
        if (n == '0) sum_q <= FP_ZERO;
      end else begin
        if (accept) cnt_q <= cnt_q + CNT_W'(1);
        if (in_valid && !in_ready) drop_q <= 1'b1;
      end
      if (load_hold) begin
        hold_q <= emerge;
        hv_q   <= 1'b1;
      end else if (clr_hv) begin
        hv_q <= 1'b0;
      end
      if (fin_go) begin
        sum_q <= hold_q;
        hv_q  <= 1'b0;
      end
    end
  end

`ifdef FP_ACC_NAN_DETECT_EN
  logic nan_q;

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr)
      nan_q <= 1'b0;
    else if (clk_en) begin
      if (start_go)
        nan_q <= 1'b0;
      else if (accept && is_nan_inf(in_data))
        nan_q <= 1'b1;
    end
  end

  assign nan_flag = nan_q;
`else
  assign nan_flag = 1'b0;
`endif

  fp_acc_tag_ring #(.L(L)) u_ring (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .clr    (ring_clr),
    .tag_in (tag_in),
    .etag   (etag),
    .count  (count)
  );

  fp_addsub_custom #(.LATENCY(L)) u_add (
    .clock   (clock),
    .aclr    (aclr),
    .clk_en  (clk_en),
    .add_sub (1'b1),
    .dataa   (dataa),
    .datab   (datab),
    .result  (emerge)
  );

endmodule

// File: tb/tb_fp_result_accumulator.sv
// Randomized bench for fp_result_accumulator against an integer-sum model.
// Define FP_ACC_NAN_DETECT_EN to expect a live nan_flag.
module tb_fp_result_accumulator;

  localparam int LAT_MAX = 68;
`ifdef FP_ACC_NAN_DETECT_EN
  localparam logic NAN_EXP = 1'b1;
`else
  localparam logic NAN_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        aclr, clk_en, start, in_valid;
  logic [15:0] n;
  logic [31:0] in_data, sum;
  logic        in_ready, busy, done, drop_err, nan_flag;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] samp[$];
  int ref_total;
  logic [31:0] got;

  fp_result_accumulator dut (
    .clock    (clock),
    .aclr     (aclr),
    .clk_en   (clk_en),
    .start    (start),
    .n        (n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .drop_err (drop_err),
    .nan_flag (nan_flag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // exact float encoding of a non-negative integer below 2^24
  function automatic logic [31:0] f2b(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++)
      if (((v >> i) & 1) != 0) p = i;
    m = (32'(v) << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int v);
    samp.push_back(f2b(v));
    ref_total += v;
  endtask

  task automatic run(input int nn, input int gap, input int stall,
                     input bit drop, input bit chk_sum,
                     output logic [31:0] res);
    int idx = 0;
    int lat = 0;
    int cyc = 0;
    bit counting = 0;
    bit seen = 0;
    bit dropped = 0;
    bit acc, en;
    start = 1'b1;
    n = 16'(nn);
    clk_en = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    while (!seen && cyc < 3000) begin
      if (done) begin
        seen = 1;
      end else begin
        clk_en = ($urandom_range(99) >= stall);
        in_valid = 1'b0;
        if (idx < nn && in_ready && $urandom_range(99) >= gap) begin
          in_valid = 1'b1;
          in_data = samp[idx];
        end else if (drop && idx == nn && !dropped) begin
          clk_en = 1'b1;
          in_valid = 1'b1;
          in_data = 32'h3F80_0000;
          dropped = 1;
        end
        acc = in_valid && clk_en && in_ready;
        en = clk_en;
        tick();
        cyc++;
        if (counting && en) lat++;
        if (acc) begin
          idx++;
          if (idx == nn) counting = 1;
        end
      end
    end
    clk_en = 1'b1;
    in_valid = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (nn > 0) chk("latency_ok", 32'(lat <= LAT_MAX), 32'd1);
    res = sum;
    if (chk_sum) chk("sum", sum, f2b(ref_total));
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    aclr = 1'b0;
    clk_en = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    n = '0;
    in_data = '0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_drop", 32'(drop_err), 32'd0);
    chk("rst_nan", 32'(nan_flag), 32'd0);
    aclr = 1'b1;
    tick();

    // 1+2+3+4 back-to-back
    samp.delete(); ref_total = 0;
    for (int v = 1; v <= 4; v++) load(v);
    run(4, 0, 0, 0, 1, got);
    chk("sum_10", got, 32'h4120_0000);
    chk("drop_clean", 32'(drop_err), 32'd0);

    // n = 0
    begin
      bit seen0 = 0;
      bit rdy0 = 0;
      start = 1'b1;
      n = '0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 2 && !seen0; c++) begin
        if (in_ready) rdy0 = 1;
        if (done) seen0 = 1;
        else tick();
      end
      chk("n0_done", 32'(seen0), 32'd1);
      chk("n0_sum", sum, 32'h0);
      chk("n0_ready", 32'(rdy0), 32'd0);
      tick();
      chk("n0_idle", 32'(busy), 32'd0);
    end

    // 100 x 1.0 with gaps and stalls
    samp.delete(); ref_total = 0;
    for (int i = 0; i < 100; i++) load(1);
    run(100, 30, 20, 0, 1, got);
    chk("sum_100", got, 32'h42C8_0000);

    // reset in the middle of ACCUM
    samp.delete(); ref_total = 0;
    start = 1'b1;
    n = 16'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'h4110_0000;
      tick();
    end
    in_valid = 1'b0;
    #2 aclr = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    #2 aclr = 1'b1;
    tick();
    load(2);
    load(3);
    run(2, 0, 0, 0, 1, got);
    chk("sum_5", got, 32'h40A0_0000);

    // extra valid after the last accept
    samp.delete(); ref_total = 0;
    load(5); load(6); load(7);
    run(3, 0, 0, 1, 1, got);
    chk("drop_set", 32'(drop_err), 32'd1);
    samp.delete(); ref_total = 0;
    load(7);
    run(1, 0, 0, 0, 1, got);
    chk("drop_cleared", 32'(drop_err), 32'd0);

    // NaN sample
    samp.delete(); ref_total = 0;
    samp.push_back(32'h7FC0_0000);
    samp.push_back(32'h3F80_0000);
    run(2, 0, 0, 0, 0, got);
    chk("nan_flag", 32'(nan_flag), 32'(NAN_EXP));

    // random runs
    for (int r = 0; r < 6; r++) begin
      int nn;
      nn = $urandom_range(40, 1);
      samp.delete(); ref_total = 0;
      for (int i = 0; i < nn; i++) load($urandom_range(1000, 0));
      run(nn, $urandom_range(60, 0), $urandom_range(40, 0), 0, 1, got);
      chk("rnd_nan_clear", 32'(nan_flag), 32'd0);
      chk("rnd_drop", 32'(drop_err), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
